// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control unit: FSM sequencing of fetch/decode/execute/memory/writeback plus retired-instruction counter.
// Optional feature: define ILLEGAL_TRAP_EN to trap on unrecognised opcodes instead of treating them as NOPs.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [2:0]       imm_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic [CNT_W-1:0] instret,
  output logic             illegal_instr
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC_R, EXEC_I, EXEC_U, ALUWB, BRANCH, JAL, JALR
`ifdef ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_t;

  state_t state, next_state;
  logic   retire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FETCH;
      instret <= '0;
    end else begin
      state <= next_state;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    imm_src    = 3'b000;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    case (state)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = DECODE;
        end
      end
      DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 3'b010;
        case (opcode)
          OP_LOAD, OP_STORE: next_state = MEMADR;
          OP_R:              next_state = EXEC_R;
          OP_I:              next_state = EXEC_I;
          OP_LUI, OP_AUIPC:  next_state = EXEC_U;
          OP_BR:             next_state = BRANCH;
          OP_JAL:            next_state = JAL;
          OP_JALR:           next_state = JALR;
`ifdef ILLEGAL_TRAP_EN
          default:           next_state = TRAP;
`else
          default:           next_state = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        if (opcode == OP_STORE) begin
          imm_src    = 3'b001;
          next_state = MEMWR;
        end else begin
          next_state = MEMRD;
        end
      end
      MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) next_state = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        next_state = FETCH;
      end
      MEMWR: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) next_state = FETCH;
      end
      EXEC_R: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b10;
        next_state = ALUWB;
      end
      EXEC_I: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b10;
        next_state = ALUWB;
      end
      EXEC_U: begin
        // LUI adds the immediate to zero, AUIPC to the old PC
        imm_src    = 3'b011;
        alu_src_b  = 2'b01;
        alu_src_a  = (opcode == OP_LUI) ? 2'b11 : 2'b01;
        next_state = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        pc_write   = branch_taken;
        next_state = FETCH;
      end
      JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        imm_src    = 3'b100;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        next_state = FETCH;
      end
      JALR: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        next_state = FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: next_state = TRAP;
`endif
      default: next_state = FETCH;
    endcase
    // Reset masks every strobe so a late mem_ready cannot complete a transfer
    if (!rst_n) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;

  assign retire = (next_state == FETCH) && (state != FETCH) && (state != TRAP);

  always_ff @(posedge clk) begin
    if (!rst_n)
      illegal_q <= 1'b0;
    else if (state == DECODE && next_state == TRAP)
      illegal_q <= 1'b1;
  end

  assign illegal_instr = illegal_q;
`else
  assign retire        = (next_state == FETCH) && (state != FETCH);
  assign illegal_instr = 1'b0;
`endif

endmodule
